// File: rtl/float_to_integer_if.sv
// float_to_integer_if: start/busy/done handshake and data bus of the float-to-int converter.
//   start      - request, sampled only while busy=0
//   a_operand  - IEEE-754 single-precision operand, captured on the accepting edge
//   busy       - conversion in progress
//   done       - one-cycle pulse, result/Exception/overflow valid
//   result     - signed 32-bit integer, truncated toward zero
//   Exception  - operand was Inf/NaN (exponent field 255)
//   overflow   - magnitude too large for int32, result saturated
interface float_to_integer_if;
    logic        start;
    logic [31:0] a_operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        Exception;
    logic        overflow;
    modport master (output start, a_operand, input busy, done, result, Exception, overflow);
    modport slave (input start, a_operand, output busy, done, result, Exception, overflow);
endinterface

// File: rtl/float_to_integer.sv
// float_to_integer: multi-cycle IEEE-754 single to int32 converter, truncation toward zero.
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset, aborts any conversion
//   bus    - float_to_integer_if.slave (start/a_operand in; busy/done/result/Exception/overflow out)
// The mantissa is aligned one bit per cycle, so a conversion takes |E-23|+2 edges
// (2 edges for Inf/NaN, |x|<1 and overflow).
module float_to_integer #(
    parameter int BIAS = 127
) (
    input logic clk,
    input logic reset,
    float_to_integer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DECODE, SHIFT, FINISH} state_t;
    localparam logic [8:0] bias9 = 9'(BIAS);
    state_t      state;
    logic [31:0] op;
    logic [31:0] mag;
    logic [4:0]  cnt;
    logic        left;
    logic        special;
    logic signed [8:0] exp_unb;
    logic [4:0]  shift_n;
    assign exp_unb = signed'({1'b0, op[30:23]}) - signed'(bias9);
    assign shift_n = exp_unb > 9'sd23 ? 5'(exp_unb - 9'sd23) : 5'(9'sd23 - exp_unb);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op            <= '0;
            mag           <= '0;
            cnt           <= '0;
            left          <= 1'b0;
            special       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.Exception <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op            <= bus.a_operand;
                        bus.busy      <= 1'b1;
                        bus.Exception <= 1'b0;
                        bus.overflow  <= 1'b0;
                        state         <= DECODE;
                    end
                end
                DECODE: begin
                    special <= 1'b1;
                    state   <= FINISH;
                    if (op[30:23] == 8'hFF) begin
                        bus.Exception <= 1'b1;
                        bus.result    <= '0;
                    end else if (exp_unb < 9'sd0) begin
                        bus.result <= '0;
                    end else if (exp_unb >= 9'sd31) begin
                        // -2^31 is the only value with E>=31 that fits in int32
                        if (op == 32'hCF00_0000) begin
                            bus.result <= 32'h8000_0000;
                        end else begin
                            bus.overflow <= 1'b1;
                            bus.result   <= op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        end
                    end else begin
                        special <= 1'b0;
                        mag     <= {8'b0, 1'b1, op[22:0]};
                        cnt     <= shift_n;
                        left    <= exp_unb > 9'sd23;
                        state   <= shift_n == 5'd0 ? FINISH : SHIFT;
                    end
                end
                SHIFT: begin
                    mag   <= left ? mag << 1 : mag >> 1;
                    cnt   <= cnt - 5'd1;
                    state <= cnt == 5'd1 ? FINISH : SHIFT;
                end
                FINISH: begin
                    if (!special)
                        bus.result <= op[31] ? -mag : mag;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_float_to_integer.sv
// tb_float_to_integer: randomized self-checking bench for float_to_integer against an arithmetic model.
module tb_float_to_integer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errs = 0;
    float_to_integer_if bus ();
    float_to_integer #(.BIAS(127)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // value = 1.m * 2^E truncated toward zero, then range-checked against int32
    function automatic void model(input logic [31:0] f, output logic [31:0] r, output logic x,
                                  output logic o, output int lat);
        int e;
        int ex;
        longint m;
        longint s;
        e = int'(f[30:23]);
        ex = e - 127;
        r = '0;
        x = 1'b0;
        o = 1'b0;
        lat = 2;
        if (e == 255) begin
            x = 1'b1;
        end else if (ex >= 0) begin
            if (ex > 38)
                m = 64'sh3FFF_FFFF_FFFF_FFFF;
            else
                m = (longint'({1'b1, f[22:0]}) << ex) >> 23;
            s = f[31] ? -m : m;
            if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
                o = 1'b1;
                r = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                r = s[31:0];
                if (ex < 31)
                    lat = (ex > 23 ? ex - 23 : 23 - ex) + 2;
            end
        end
    endfunction
    // now=1 drives start in the current cycle (used right after a done pulse);
    // poke=1 pulses start with another operand while busy
    task automatic convert(input logic [31:0] f, input bit now, input bit poke);
        logic [31:0] er;
        logic        ex;
        logic        eo;
        int          el;
        int          lat;
        model(f, er, ex, eo, el);
        if (!now)
            @(negedge clk);
        bus.start = 1'b1;
        bus.a_operand = f;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_accept", {31'b0, bus.busy}, 32'd1);
        chk("exc_cleared", {31'b0, bus.Exception}, 32'd0);
        chk("ovf_cleared", {31'b0, bus.overflow}, 32'd0);
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (poke && k == 2) begin
                bus.start = 1'b1;
                bus.a_operand = 32'h4E80_0000;
            end
            if (poke && k == 4)
                bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done)
                lat = k;
        end
        chk($sformatf("latency %h", f), lat, el);
        chk($sformatf("result %h", f), bus.result, er);
        chk($sformatf("exception %h", f), {31'b0, bus.Exception}, {31'b0, ex});
        chk($sformatf("overflow %h", f), {31'b0, bus.overflow}, {31'b0, eo});
        chk($sformatf("busy_at_done %h", f), {31'b0, bus.busy}, 32'd0);
    endtask
    initial begin
        logic [31:0] f;
        bit          seen;
        bus.start = 1'b0;
        bus.a_operand = '0;
        #1;
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        chk("reset_done", {31'b0, bus.done}, 32'd0);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_exc", {31'b0, bus.Exception}, 32'd0);
        chk("reset_ovf", {31'b0, bus.overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        convert(32'h3F80_0000, 0, 0);
        convert(32'h4070_0000, 0, 0);
        convert(32'hC480_0000, 0, 0);
        convert(32'h4E80_0000, 0, 0);
        convert(32'h4F00_0000, 0, 0);
        convert(32'hCF00_0000, 0, 0);
        convert(32'h7F80_0000, 0, 0);
        convert(32'h7FC0_0000, 0, 0);
        convert(32'h3F00_0000, 0, 0);
        convert(32'h8000_0000, 0, 0);
        convert(32'h4B00_0000, 0, 0);
        convert(32'hCEFF_FFFF, 0, 0);
        convert(32'hFF80_0000, 0, 0);
        convert(32'h3FC0_0000, 0, 1);
        convert(32'h7F80_0000, 0, 0);
        convert(32'h3F80_0000, 1, 0);
        convert(32'h4F80_0000, 1, 0);
        convert(32'hC000_0000, 1, 0);
        // reset in the middle of a 1.0 conversion, between edge 9 and edge 10
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_operand = 32'h3F80_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_busy", {31'b0, bus.busy}, 32'd0);
        chk("midreset_result", bus.result, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            seen |= bus.done;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            seen |= bus.done;
        end
        chk("midreset_no_done", {31'b0, seen}, 32'd0);
        convert(32'h3F80_0000, 0, 0);
        for (int i = 0; i < 200; i++) begin
            f = $urandom;
            if (i % 4 != 0)
                f[30:23] = 8'($urandom_range(120, 160));
            convert(f, i % 5 == 0, i % 7 == 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
